// File: rtl/riscv_divcl_seq_if.sv
// Handshake and data bundle for the sequential carry-less divider.
interface riscv_divcl_seq_if;
  logic        start_i;
  logic        abort_i;
  logic [31:0] dividend_h_i;
  logic [31:0] dividend_l_i;
  logic [31:0] divisor_i;
  logic        ready_o;
  logic        valid_o;
  logic        dbz_o;
  logic [31:0] quotient_h_o;
  logic [31:0] quotient_l_o;
  logic [31:0] remainder_o;

  modport master (
    output start_i, abort_i, dividend_h_i, dividend_l_i, divisor_i,
    input  ready_o, valid_o, dbz_o, quotient_h_o, quotient_l_o, remainder_o
  );

  modport slave (
    input  start_i, abort_i, dividend_h_i, dividend_l_i, divisor_i,
    output ready_o, valid_o, dbz_o, quotient_h_o, quotient_l_o, remainder_o
  );
endinterface

// File: rtl/riscv_divcl_seq.sv
// Sequential GF(2)[x] divider: 64-bit dividend by 32-bit divisor, one quotient
// bit per cycle, MSB first, under a start/ready/valid handshake.
module riscv_divcl_seq (
  input  logic               clk,
  input  logic               rst_n,
  riscv_divcl_seq_if.slave   bus
);

  localparam int unsigned DW = 64;
  localparam int unsigned RW = 32;
  localparam int unsigned DBITS = 5;
  localparam int unsigned CBITS = 6;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [DW-1:0]      a_q;
  logic [DW-1:0]      q_q;
  logic [RW-1:0]      b_q;
  logic [RW-1:0]      r_q;
  logic [DBITS-1:0]   d_q;
  logic [CBITS-1:0]   cnt_q;
  logic               dbz_q;
  logic               ready_q;
  logic               valid_q;

  logic               accept_c;
  logic               accept_dbz_c;
  logic               iterate_c;
  logic [DBITS-1:0]   msb_c;
  logic [RW-1:0]      r_shift_c;
  logic               q_bit_c;
  logic [RW-1:0]      r_iter_c;

  // Degree of the incoming divisor (highest set bit wins).
  always_comb begin
    msb_c = '0;
    for (int i = 0; i < int'(RW); i++) begin
      if (bus.divisor_i[i]) msb_c = DBITS'(i);
    end
  end

  // One long-division step; deg(R) < d keeps the shifted value inside 32 bits.
  always_comb begin
    r_shift_c = {r_q[RW-2:0], a_q[DW-1]};
    q_bit_c   = r_shift_c[d_q];
    r_iter_c  = q_bit_c ? (r_shift_c ^ b_q) : r_shift_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and datapath enables; abort overrides everything.
  always_comb begin
    state_d      = state_q;
    accept_c     = 1'b0;
    accept_dbz_c = 1'b0;
    iterate_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.divisor_i != '0) begin
            state_d  = BUSY;
            accept_c = 1'b1;
          end else begin
            state_d      = DONE;
            accept_dbz_c = 1'b1;
          end
        end
      end
      BUSY: begin
        iterate_c = 1'b1;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort_i) begin
      state_d      = IDLE;
      accept_c     = 1'b0;
      accept_dbz_c = 1'b0;
      iterate_c    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      if (accept_c) begin
        a_q   <= {bus.dividend_h_i, bus.dividend_l_i};
        b_q   <= bus.divisor_i;
        d_q   <= msb_c;
        q_q   <= '0;
        r_q   <= '0;
        cnt_q <= CBITS'(DW - 1);
        dbz_q <= 1'b0;
      end else if (accept_dbz_c) begin
        q_q   <= '0;
        r_q   <= bus.dividend_l_i;
        dbz_q <= 1'b1;
      end else if (iterate_c) begin
        a_q   <= {a_q[DW-2:0], 1'b0};
        r_q   <= r_iter_c;
        q_q   <= {q_q[DW-2:0], q_bit_c};
        cnt_q <= cnt_q - CBITS'(1);
      end
      ready_q <= (state_d == IDLE);
      valid_q <= (state_d == DONE);
    end
  end

  assign bus.ready_o      = ready_q;
  assign bus.valid_o      = valid_q;
  assign bus.dbz_o        = dbz_q;
  assign bus.quotient_h_o = q_q[DW-1:RW];
  assign bus.quotient_l_o = q_q[RW-1:0];
  assign bus.remainder_o  = r_q;

endmodule

// File: tb/tb_riscv_divcl_seq.sv
// Scoreboard bench for the sequential carry-less divider.
module tb_riscv_divcl_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  riscv_divcl_seq_if bus();

  riscv_divcl_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  // Reference polynomial long division by degree reduction; returns {Q, R}.
  function automatic logic [95:0] ref_div(input logic [63:0] n, input logic [31:0] b);
    int db = 0;
    logic [63:0] rem = n;
    logic [63:0] q = '0;
    for (int i = 0; i < 32; i++) if (b[i]) db = i;
    for (int i = 63; i >= db; i--) begin
      if (rem[i]) begin
        rem = rem ^ (64'(b) << (i - db));
        q[i - db] = 1'b1;
      end
    end
    return {q, rem[31:0]};
  endfunction

  function automatic logic [95:0] clmul(input logic [63:0] a, input logic [31:0] b);
    logic [95:0] p = '0;
    for (int i = 0; i < 32; i++) if (b[i]) p = p ^ (96'(a) << i);
    return p;
  endfunction

  task automatic issue(input logic [63:0] n, input logic [31:0] b,
                       input logic [63:0] eq, input logic [31:0] er,
                       input logic edbz, input int elat);
    int guard = 0;
    while (bus.ready_o !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    bus.dividend_h_i = n[63:32];
    bus.dividend_l_i = n[31:0];
    bus.divisor_i    = b;
    bus.start_i      = 1'b1;
    sb.push_back('{eq, er, edbz, elat});
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (bus.valid_o !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    bus.dividend_h_i = '0; bus.dividend_l_i = '0; bus.divisor_i = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ready_o, bus.valid_o, bus.dbz_o, bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o} !== {1'b1, 1'b0, 1'b0, 96'd0}) begin
      failures++;
      $display("FAIL reset_init: ready=%b valid=%b dbz=%b q=%h_%h r=%h, want ready=1 valid=0 all zero",
               bus.ready_o, bus.valid_o, bus.dbz_o, bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o);
    end
    @(negedge clk) rst_n = 1'b1;
    // Start a division, then yank reset mid-BUSY between clock edges.
    @(negedge clk);
    bus.dividend_h_i = 32'hFFFF_FFFF; bus.dividend_l_i = 32'hFFFF_FFFF; bus.divisor_i = 32'h3;
    bus.start_i = 1'b1;
    @(negedge clk) bus.start_i = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ready_o, bus.valid_o, bus.dbz_o, bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o} !== {1'b1, 1'b0, 1'b0, 96'd0}) begin
      failures++;
      $display("FAIL reset_mid: ready=%b valid=%b dbz=%b q=%h_%h r=%h, want ready=1 valid=0 all zero",
               bus.ready_o, bus.valid_o, bus.dbz_o, bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_small();
    int lat;
    exp_t e;
    issue(64'hF, 32'h3, 64'h5, 32'h0, 1'b0, 65);
    wait_valid(lat);
    e = sb.pop_front();
    checks++;
    if ({bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o, bus.dbz_o, bus.ready_o, lat} !== {e.q, e.r, e.dbz, 1'b0, e.lat}) begin
      failures++;
      $display("FAIL small: q=%h_%h r=%h dbz=%b ready=%b lat=%0d, want q=%h r=%h dbz=%b ready=0 lat=%0d",
               bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o, bus.dbz_o, bus.ready_o, lat, e.q, e.r, e.dbz, e.lat);
    end
    @(negedge clk);
    checks++;
    if ({bus.valid_o, bus.ready_o} !== 2'b01) begin
      failures++;
      $display("FAIL small_strobe: valid=%b ready=%b, want valid=0 ready=1", bus.valid_o, bus.ready_o);
    end
  endtask

  task automatic test_shift();
    int lat;
    exp_t e;
    issue(64'h12345678_9ABCDEF0, 32'h8000_0000, 64'h00000000_2468ACF1, 32'h1ABCDEF0, 1'b0, 65);
    wait_valid(lat);
    e = sb.pop_front();
    checks++;
    if ({bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o, bus.dbz_o, bus.ready_o, lat} !== {e.q, e.r, e.dbz, 1'b0, e.lat}) begin
      failures++;
      $display("FAIL shift_msb: q=%h_%h r=%h dbz=%b ready=%b lat=%0d, want q=%h r=%h dbz=%b ready=0 lat=%0d",
               bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o, bus.dbz_o, bus.ready_o, lat, e.q, e.r, e.dbz, e.lat);
    end
    issue(64'h12345678_9ABCDEF0, 32'h1, 64'h12345678_9ABCDEF0, 32'h0, 1'b0, 65);
    wait_valid(lat);
    e = sb.pop_front();
    checks++;
    if ({bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o, bus.dbz_o, bus.ready_o, lat} !== {e.q, e.r, e.dbz, 1'b0, e.lat}) begin
      failures++;
      $display("FAIL shift_one: q=%h_%h r=%h dbz=%b ready=%b lat=%0d, want q=%h r=%h dbz=%b ready=0 lat=%0d",
               bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o, bus.dbz_o, bus.ready_o, lat, e.q, e.r, e.dbz, e.lat);
    end
    // Dividend degree below divisor degree: all remainder.
    issue(64'h0000_0000_0000_00A5, 32'h0001_0000, 64'h0, 32'h0000_00A5, 1'b0, 65);
    wait_valid(lat);
    e = sb.pop_front();
    checks++;
    if ({bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o, bus.dbz_o, bus.ready_o, lat} !== {e.q, e.r, e.dbz, 1'b0, e.lat}) begin
      failures++;
      $display("FAIL low_degree: q=%h_%h r=%h dbz=%b ready=%b lat=%0d, want q=%h r=%h dbz=%b ready=0 lat=%0d",
               bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o, bus.dbz_o, bus.ready_o, lat, e.q, e.r, e.dbz, e.lat);
    end
  endtask

  task automatic test_dbz();
    int lat;
    exp_t e;
    issue({32'h1111_2222, 32'hDEAD_BEEF}, 32'h0, 64'h0, 32'hDEAD_BEEF, 1'b1, 1);
    wait_valid(lat);
    e = sb.pop_front();
    checks++;
    if ({bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o, bus.dbz_o, bus.ready_o, lat} !== {e.q, e.r, e.dbz, 1'b0, e.lat}) begin
      failures++;
      $display("FAIL dbz: q=%h_%h r=%h dbz=%b ready=%b lat=%0d, want q=%h r=%h dbz=%b ready=0 lat=%0d",
               bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o, bus.dbz_o, bus.ready_o, lat, e.q, e.r, e.dbz, e.lat);
    end
    @(negedge clk);
    checks++;
    if ({bus.valid_o, bus.ready_o} !== 2'b01) begin
      failures++;
      $display("FAIL dbz_ready: valid=%b ready=%b, want valid=0 ready=1", bus.valid_o, bus.ready_o);
    end
  endtask

  task automatic test_abort();
    logic [63:0] n = 64'h12345678_9ABCDEF0;
    logic [31:0] b = 32'h0000_011B;
    logic [95:0] part;
    logic        saw_valid = 1'b0;
    int          lat;
    exp_t        e;
    // After 19 iterations Q/R equal the division of the top 19 dividend bits.
    part = ref_div(n >> 45, b);
    @(negedge clk);
    bus.dividend_h_i = n[63:32]; bus.dividend_l_i = n[31:0]; bus.divisor_i = b;
    bus.start_i = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 20; c++) begin
      bus.start_i = (c == 10);
      bus.abort_i = (c == 20);
      if (c == 10) begin
        bus.dividend_h_i = 32'hFFFF_FFFF; bus.dividend_l_i = 32'h0; bus.divisor_i = 32'h7;
      end
      @(negedge clk);
      if (bus.valid_o === 1'b1) saw_valid = 1'b1;
    end
    bus.abort_i = 1'b0;
    checks++;
    if ({saw_valid, bus.ready_o, bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o} !== {1'b0, 1'b1, part}) begin
      failures++;
      $display("FAIL abort: saw_valid=%b ready=%b q=%h_%h r=%h, want saw_valid=0 ready=1 q=%h r=%h",
               saw_valid, bus.ready_o, bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o, part[95:32], part[31:0]);
    end
    // Start together with abort in IDLE is dropped.
    bus.dividend_h_i = 32'h0; bus.dividend_l_i = 32'hF; bus.divisor_i = 32'h3;
    bus.start_i = 1'b1; bus.abort_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.valid_o, bus.ready_o, bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o} !== {1'b0, 1'b1, part}) begin
      failures++;
      $display("FAIL abort_start: valid=%b ready=%b q=%h_%h r=%h, want valid=0 ready=1 q=%h r=%h",
               bus.valid_o, bus.ready_o, bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o, part[95:32], part[31:0]);
    end
    part = ref_div(n, b);
    issue(n, b, part[95:32], part[31:0], 1'b0, 65);
    wait_valid(lat);
    e = sb.pop_front();
    checks++;
    if ({bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o, bus.dbz_o, bus.ready_o, lat} !== {e.q, e.r, e.dbz, 1'b0, e.lat}) begin
      failures++;
      $display("FAIL abort_restart: q=%h_%h r=%h dbz=%b ready=%b lat=%0d, want q=%h r=%h dbz=%b ready=0 lat=%0d",
               bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o, bus.dbz_o, bus.ready_o, lat, e.q, e.r, e.dbz, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 300; k++) begin
      logic [63:0] n;
      logic [31:0] b;
      logic [95:0] m;
      int lat;
      int db;
      exp_t e;
      n = {$urandom, $urandom} >> $urandom_range(0, 63);
      b = $urandom >> $urandom_range(0, 31);
      if (k % 16 == 7) b = 32'h0;
      else if (b == 32'h0) b = 32'h1;
      if (b == 32'h0) issue(n, b, 64'h0, n[31:0], 1'b1, 1);
      else begin
        m = ref_div(n, b);
        issue(n, b, m[95:32], m[31:0], 1'b0, 65);
      end
      wait_valid(lat);
      e = sb.pop_front();
      checks++;
      if ({bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o, bus.dbz_o, bus.ready_o, lat} !== {e.q, e.r, e.dbz, 1'b0, e.lat}) begin
        failures++;
        $display("FAIL rand[%0d] n=%h b=%h: q=%h_%h r=%h dbz=%b ready=%b lat=%0d, want q=%h r=%h dbz=%b ready=0 lat=%0d",
                 k, n, b, bus.quotient_h_o, bus.quotient_l_o, bus.remainder_o, bus.dbz_o, bus.ready_o, lat, e.q, e.r, e.dbz, e.lat);
      end
      if (b != 32'h0) begin
        db = 0;
        for (int i = 0; i < 32; i++) if (b[i]) db = i;
        m = clmul({bus.quotient_h_o, bus.quotient_l_o}, b) ^ {64'd0, bus.remainder_o};
        checks++;
        if (m !== {32'd0, n} || (bus.remainder_o >> db) != 32'd0) begin
          failures++;
          $display("FAIL identity[%0d]: clmul(Q,b)^R=%h r=%h deg(b)=%0d, want %h with deg(R)<deg(b)",
                   k, m, bus.remainder_o, db, n);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_shift();
    test_dbz();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
